memcyc_resp: RTL and testbench
==============================

MEMCYC_RESP -- requirements
Module: memcyc_resp

Interface
REQ-001 Parameter ADDR_WIDTH, default 20, width of physical word address presented to memory.
REQ-002 Parameter MEMSIZE, default 2**20, number of implemented words; addresses >= MEMSIZE are nonexistent.
REQ-003 Parameter TIMEOUT, default 63, max cycles awaiting memRDY before NXM abort.
REQ-004 clk  input  1  clock; reset rst, asynchronous, active-high.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 clken  input  1  CPU clock enable; qualifies reqSTART and wrSTB only.
REQ-007 reqSTART  input  1  VMA loaded; new memory cycle requested.
REQ-008 reqREAD, reqWRITE  input  1 each  cycle type from VMA; both set = read-modify-write (RMW).
REQ-009 reqADDR  input  ADDR_WIDTH  physical word address.
REQ-010 cpuDOUT  input  36  CPU write data.
REQ-011 wrSTB  input  1  CPU write data valid for RMW write phase.
REQ-012 nxmCLR  input  1  clears nxmERR.
REQ-013 cpuDIN  output  36  read data to CPU.
REQ-014 memWAIT  output  1  CPU stall request.
REQ-015 memACK  output  1  one-cycle completion pulse.
REQ-016 nxmERR  output  1  sticky nonexistent-memory flag.
REQ-017 memADDR  output  ADDR_WIDTH; memDOUT output 36; memRD, memWR output 1 each: memory port.
REQ-018 memDIN  input  36; memRDY  input  1: memory read data and completion.

Function
REQ-019 States: IDLE, RD, WR, RMWHOLD, ACK, NXM.
REQ-020 Start = clken & reqSTART & (reqREAD | reqWRITE) in IDLE; start in any other state, or with neither type bit, is ignored.
REQ-021 On start: latch reqADDR to memADDR, latch cpuDOUT to memDOUT, latch RMW flag, clear timeout counter.
REQ-022 On start with reqADDR >= MEMSIZE: next state NXM, memRD/memWR never asserted.
REQ-023 Otherwise reqREAD set -> RD; reqWRITE only -> WR.
REQ-024 memRD = 1 exactly while in RD; memWR = 1 exactly while in WR; never both.
REQ-025 memWAIT = 1 in RD, WR, NXM, and ACK; 0 in IDLE and RMWHOLD.
REQ-026 RD with memRDY: capture memDIN into cpuDIN same edge; RMW -> RMWHOLD, else -> ACK.
REQ-027 WR with memRDY -> ACK.
REQ-028 RMWHOLD: memACK pulses one cycle on entry; clken & wrSTB captures cpuDOUT into memDOUT, clears counter, -> WR.
REQ-029 ACK: memACK = 1 for one cycle, then IDLE.
REQ-030 Timeout counter, 8 bits saturating, increments each cycle in RD or WR while memRDY = 0; counter == TIMEOUT with memRDY = 0 -> NXM; memRDY in that same cycle wins (normal completion).
REQ-031 NXM (one cycle): set nxmERR, force cpuDIN = 0, assert memACK, -> IDLE; memRD/memWR deasserted.
REQ-032 nxmCLR clears nxmERR; simultaneous set in NXM wins over clear.
REQ-033 Start latency: memRD/memWR assert on the first clk edge after start; memACK earliest 2 cycles after memRDY edge-sampled... specifically memACK asserts the cycle after the memRDY-sampling edge.
REQ-034 cpuDIN holds its last value until next read capture or NXM.

Reset
REQ-035 rst asynchronously forces IDLE; cpuDIN, memADDR, memDOUT = 0; memRD, memWR, memWAIT, memACK, nxmERR = 0; counter = 0.
REQ-036 rst mid-cycle drops memRD/memWR immediately; no memACK is generated for the aborted cycle.

Verification
REQ-037 Read: addr 0x00100, memRDY after 3 cycles with memDIN 0o123456701234 -> memRD high 3 cycles, cpuDIN = 0o123456701234, single memACK, memWAIT low after ACK.
REQ-038 Write: addr 0x00200, cpuDOUT 0o777777000000, memRDY immediately -> memWR one cycle, memDOUT = 0o777777000000, memACK next cycle.
REQ-039 RMW: read returns 5, memACK, memWAIT low in RMWHOLD; wrSTB with cpuDOUT 6 -> memWR with memDOUT 6, second memACK.
REQ-040 Timeout: memRDY held low -> abort after 63 cycles, NXM, nxmERR = 1, cpuDIN = 0; nxmCLR -> nxmERR = 0.
REQ-041 Out-of-range: MEMSIZE = 1024, addr 1024 -> no memRD, NXM next cycle, nxmERR = 1.
REQ-042 rst asserted during RD -> memRD drops asynchronously, no memACK, new start accepted after release.

Source files
------------

// File: rtl/memcyc_resp_if.sv
// rtl/memcyc_resp_if.sv - memory-port bundle between the cycle responder and physical memory
// Purpose: groups the word-addressed memory port into one connection.
// Signals:
//   memADDR  [ADDR_WIDTH] word address presented to memory
//   memDOUT  [36]         write data to memory
//   memRD, memWR          read / write strobes, held for the whole access
//   memDIN   [36]         read data from memory
//   memRDY                access complete (read data valid / write taken)
// Modports: master = responder side, slave = memory side.
interface memcyc_resp_if #(
   parameter int ADDR_WIDTH = 20
) ();
   logic [ADDR_WIDTH-1:0] memADDR;
   logic [35:0]           memDOUT;
   logic                  memRD;
   logic                  memWR;
   logic [35:0]           memDIN;
   logic                  memRDY;

   modport master (
      output memADDR, memDOUT, memRD, memWR,
      input  memDIN, memRDY
   );

   modport slave (
      input  memADDR, memDOUT, memRD, memWR,
      output memDIN, memRDY
   );
endinterface

// File: rtl/memcyc_resp.sv
// rtl/memcyc_resp.sv - CPU memory-cycle responder with timeout and NXM abort
// Purpose: turns a VMA cycle request (read, write or read-modify-write) into
// memory port strobes, stalls the CPU until completion, and aborts to a sticky
// nonexistent-memory error on out-of-range address or memRDY timeout.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   clken                 CPU clock enable, qualifies reqSTART and wrSTB
//   reqSTART/READ/WRITE   cycle request; READ and WRITE together = RMW
//   reqADDR, cpuDOUT      request address and CPU write data
//   wrSTB                 RMW write-phase data valid
//   nxmCLR                clears nxmERR
//   cpuDIN                read data to CPU
//   memWAIT, memACK       CPU stall and one-cycle completion pulse
//   nxmERR                sticky nonexistent-memory flag
//   mem                   memory port (memcyc_resp_if.master)
module memcyc_resp #(
   parameter int ADDR_WIDTH = 20,
   parameter int MEMSIZE    = 2**20,
   parameter int TIMEOUT    = 63
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clken,
   input  logic                  reqSTART,
   input  logic                  reqREAD,
   input  logic                  reqWRITE,
   input  logic [ADDR_WIDTH-1:0] reqADDR,
   input  logic [35:0]           cpuDOUT,
   input  logic                  wrSTB,
   input  logic                  nxmCLR,
   output logic [35:0]           cpuDIN,
   output logic                  memWAIT,
   output logic                  memACK,
   output logic                  nxmERR,
   memcyc_resp_if.master         mem
);

   typedef enum logic [2:0] {IDLE, RD, WR, RMWHOLD, ACK, NXM} state_t;

   localparam logic [7:0]  TMO_C     = 8'(TIMEOUT);
   localparam logic [32:0] MEMSIZE_C = 33'(MEMSIZE);

   state_t                state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [35:0]           dout_q, dout_d;
   logic [35:0]           din_q, din_d;
   logic                  rmw_q, rmw_d;
   logic                  nxm_q, nxm_d;
   logic                  hold_ack_q;

   logic start;
   logic oob;

   assign start = clken && reqSTART && (reqREAD || reqWRITE);
   // Widened compare so MEMSIZE = 2**ADDR_WIDTH never truncates.
   assign oob   = ({{(33-ADDR_WIDTH){1'b0}}, reqADDR} >= MEMSIZE_C);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         dout_q     <= '0;
         din_q      <= '0;
         rmw_q      <= 1'b0;
         nxm_q      <= 1'b0;
         hold_ack_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         dout_q     <= dout_d;
         din_q      <= din_d;
         rmw_q      <= rmw_d;
         nxm_q      <= nxm_d;
         // Read phase of an RMW acknowledges once, on the first RMWHOLD cycle.
         hold_ack_q <= (state_q == RD) && (state_d == RMWHOLD);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      dout_d  = dout_q;
      din_d   = din_q;
      rmw_d   = rmw_q;
      nxm_d   = nxm_q;

      if (nxmCLR) nxm_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               addr_d = reqADDR;
               dout_d = cpuDOUT;
               rmw_d  = reqREAD && reqWRITE;
               cnt_d  = '0;
               if (oob) begin
                  state_d = NXM;
                  din_d   = '0;
               end else if (reqREAD) begin
                  state_d = RD;
               end else begin
                  state_d = WR;
               end
            end
         end
         RD, WR: begin
            // memRDY on the terminal count still completes normally.
            if (mem.memRDY) begin
               if (state_q == RD) begin
                  din_d   = mem.memDIN;
                  state_d = rmw_q ? RMWHOLD : ACK;
               end else begin
                  state_d = ACK;
               end
            end else if (cnt_q == TMO_C) begin
               state_d = NXM;
               din_d   = '0;
            end else if (cnt_q != 8'hFF) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RMWHOLD: begin
            if (clken && wrSTB) begin
               dout_d  = cpuDOUT;
               cnt_d   = '0;
               state_d = WR;
            end
         end
         ACK: state_d = IDLE;
         NXM: begin
            nxm_d   = 1'b1;   // set wins over a simultaneous nxmCLR
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem.memADDR = addr_q;
   assign mem.memDOUT = dout_q;
   assign mem.memRD   = (state_q == RD);
   assign mem.memWR   = (state_q == WR);
   assign cpuDIN      = din_q;
   assign nxmERR      = nxm_q;
   assign memWAIT     = (state_q == RD) || (state_q == WR) ||
                        (state_q == ACK) || (state_q == NXM);
   assign memACK      = (state_q == ACK) || (state_q == NXM) || hold_ack_q;

endmodule

// File: tb/tb_memcyc_resp.sv
// tb/tb_memcyc_resp.sv - scoreboard bench for memcyc_resp
module tb_memcyc_resp;
   localparam int AW  = 20;
   localparam int MS  = 1024;
   localparam int TMO = 63;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clken = 1'b0, reqSTART = 1'b0, reqREAD = 1'b0, reqWRITE = 1'b0;
   logic [AW-1:0] reqADDR = '0;
   logic [35:0]   cpuDOUT = '0;
   logic          wrSTB = 1'b0, nxmCLR = 1'b0;
   logic [35:0]   cpuDIN;
   logic          memWAIT, memACK, nxmERR;

   memcyc_resp_if #(.ADDR_WIDTH(AW)) mem_if ();

   memcyc_resp #(.ADDR_WIDTH(AW), .MEMSIZE(MS), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .clken(clken), .reqSTART(reqSTART),
      .reqREAD(reqREAD), .reqWRITE(reqWRITE), .reqADDR(reqADDR),
      .cpuDOUT(cpuDOUT), .wrSTB(wrSTB), .nxmCLR(nxmCLR), .cpuDIN(cpuDIN),
      .memWAIT(memWAIT), .memACK(memACK), .nxmERR(nxmERR), .mem(mem_if)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   logic [35:0] exp_q[$];
   logic [35:0] exp_din;

   // memory responder: memRDY after rdy_delay strobe cycles (-1 = never)
   int          rdy_delay = -1;
   logic [35:0] rdata = '0;
   int          wait_cnt = 0;
   int          rd_cycles = 0, wr_cycles = 0, ack_cnt = 0;

   initial begin
      mem_if.memRDY = 1'b0;
      mem_if.memDIN = '0;
      forever begin
         @(posedge clk); #1;
         if (rst) begin
            mem_if.memRDY = 1'b0;
            wait_cnt = 0;
         end else if (mem_if.memRD || mem_if.memWR) begin
            if (rdy_delay >= 0 && wait_cnt == rdy_delay) begin
               mem_if.memRDY = 1'b1;
               mem_if.memDIN = rdata;
            end else begin
               mem_if.memRDY = 1'b0;
            end
            wait_cnt++;
         end else begin
            mem_if.memRDY = 1'b0;
            wait_cnt = 0;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (mem_if.memRD) rd_cycles++;
      if (mem_if.memWR) wr_cycles++;
      if (memACK) ack_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic start(input logic [AW-1:0] a, input logic r, input logic w, input logic [35:0] d);
      @(posedge clk); #1;
      clken = 1'b1; reqSTART = 1'b1; reqREAD = r; reqWRITE = w; reqADDR = a; cpuDOUT = d;
      @(posedge clk); #1;
      reqSTART = 1'b0; reqREAD = 1'b0; reqWRITE = 1'b0;
   endtask

   // Returns the number of negedges until memACK, or -1 if the budget expires.
   task automatic wait_ack(input int max, output int waited);
      for (int i = 1; i <= max; i++) begin
         @(negedge clk); #1;
         if (memACK) begin
            waited = i;
            return;
         end
      end
      waited = -1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      tests++; if (cpuDIN !== 36'd0) begin fails++; $display("FAIL reset_cpuDIN: got %h want 0", cpuDIN); end
      tests++; if (mem_if.memADDR !== '0 || mem_if.memDOUT !== 36'd0) begin fails++; $display("FAIL reset_bus: addr %h dout %h want 0", mem_if.memADDR, mem_if.memDOUT); end
      tests++; if ({mem_if.memRD, mem_if.memWR, memWAIT, memACK, nxmERR} !== 5'b0) begin fails++; $display("FAIL reset_ctl: got %b want 00000", {mem_if.memRD, mem_if.memWR, memWAIT, memACK, nxmERR}); end
      rst = 1'b0;
   endtask

   task automatic test_read();
      int w, rd0, ack0;
      rd0 = rd_cycles; ack0 = ack_cnt;
      rdy_delay = 2; rdata = 36'o123456701234;
      exp_q.push_back(36'o123456701234);
      start(20'h00100, 1'b1, 1'b0, 36'd0);
      wait_ack(20, w);
      exp_din = exp_q.pop_front();
      tests++; if (w !== 4) begin fails++; $display("FAIL read_latency: got %0d want 4", w); end
      tests++; if (cpuDIN !== exp_din) begin fails++; $display("FAIL read_data: got %o want %o", cpuDIN, exp_din); end
      tests++; if (rd_cycles - rd0 !== 3) begin fails++; $display("FAIL read_rd_cycles: got %0d want 3", rd_cycles - rd0); end
      tests++; if (mem_if.memADDR !== 20'h00100) begin fails++; $display("FAIL read_addr: got %h want 00100", mem_if.memADDR); end
      tests++; if (memWAIT !== 1'b1 || mem_if.memRD !== 1'b0) begin fails++; $display("FAIL read_ack_state: wait %b rd %b want 1 0", memWAIT, mem_if.memRD); end
      @(negedge clk); #1;
      tests++; if (memACK !== 1'b0 || memWAIT !== 1'b0) begin fails++; $display("FAIL read_after: ack %b wait %b want 0 0", memACK, memWAIT); end
      tests++; if (ack_cnt - ack0 !== 1) begin fails++; $display("FAIL read_ack_count: got %0d want 1", ack_cnt - ack0); end
   endtask

   task automatic test_write();
      int w, wr0;
      wr0 = wr_cycles;
      rdy_delay = 0;
      start(20'h00200, 1'b0, 1'b1, 36'o777777000000);
      wait_ack(20, w);
      tests++; if (w !== 2) begin fails++; $display("FAIL write_latency: got %0d want 2", w); end
      tests++; if (wr_cycles - wr0 !== 1) begin fails++; $display("FAIL write_wr_cycles: got %0d want 1", wr_cycles - wr0); end
      tests++; if (mem_if.memDOUT !== 36'o777777000000) begin fails++; $display("FAIL write_data: got %o want 777777000000", mem_if.memDOUT); end
      tests++; if (cpuDIN !== 36'o123456701234) begin fails++; $display("FAIL write_din_hold: got %o want 123456701234", cpuDIN); end
   endtask

   task automatic test_rmw();
      int w, rd0, wr0, ack0;
      rd0 = rd_cycles; wr0 = wr_cycles; ack0 = ack_cnt;
      rdy_delay = 0; rdata = 36'd5;
      exp_q.push_back(36'd5);
      start(20'h00300, 1'b1, 1'b1, 36'o777);
      wait_ack(20, w);
      exp_din = exp_q.pop_front();
      tests++; if (w !== 2) begin fails++; $display("FAIL rmw_read_latency: got %0d want 2", w); end
      tests++; if (cpuDIN !== exp_din) begin fails++; $display("FAIL rmw_read_data: got %h want %h", cpuDIN, exp_din); end
      tests++; if (memWAIT !== 1'b0 || mem_if.memDOUT !== 36'o777) begin fails++; $display("FAIL rmw_hold: wait %b dout %o want 0 777", memWAIT, mem_if.memDOUT); end
      @(negedge clk); #1;
      tests++; if (memACK !== 1'b0 || memWAIT !== 1'b0 || mem_if.memWR !== 1'b0) begin fails++; $display("FAIL rmw_hold2: ack %b wait %b wr %b want 0 0 0", memACK, memWAIT, mem_if.memWR); end
      @(posedge clk); #1;
      clken = 1'b1; wrSTB = 1'b1; cpuDOUT = 36'd6;
      @(posedge clk); #1;
      wrSTB = 1'b0;
      wait_ack(20, w);
      tests++; if (w !== 2) begin fails++; $display("FAIL rmw_write_latency: got %0d want 2", w); end
      tests++; if (mem_if.memDOUT !== 36'd6) begin fails++; $display("FAIL rmw_write_data: got %h want 6", mem_if.memDOUT); end
      tests++; if (rd_cycles - rd0 !== 1 || wr_cycles - wr0 !== 1) begin fails++; $display("FAIL rmw_strobes: rd %0d wr %0d want 1 1", rd_cycles - rd0, wr_cycles - wr0); end
      tests++; if (ack_cnt - ack0 !== 2) begin fails++; $display("FAIL rmw_ack_count: got %0d want 2", ack_cnt - ack0); end
   endtask

   task automatic test_timeout();
      int w, rd0;
      rd0 = rd_cycles;
      rdy_delay = -1;
      exp_q.push_back(36'd0);
      start(20'h00010, 1'b1, 1'b0, 36'd0);
      wait_ack(200, w);
      exp_din = exp_q.pop_front();
      tests++; if (w !== TMO + 2) begin fails++; $display("FAIL tmo_latency: got %0d want %0d", w, TMO + 2); end
      tests++; if (rd_cycles - rd0 !== TMO + 1) begin fails++; $display("FAIL tmo_rd_cycles: got %0d want %0d", rd_cycles - rd0, TMO + 1); end
      tests++; if (cpuDIN !== exp_din || mem_if.memRD !== 1'b0 || memWAIT !== 1'b1) begin fails++; $display("FAIL tmo_nxm: din %h rd %b wait %b want 0 0 1", cpuDIN, mem_if.memRD, memWAIT); end
      @(negedge clk); #1;
      tests++; if (nxmERR !== 1'b1 || memWAIT !== 1'b0) begin fails++; $display("FAIL tmo_err: err %b wait %b want 1 0", nxmERR, memWAIT); end
      @(posedge clk); #1; nxmCLR = 1'b1;
      @(posedge clk); #1; nxmCLR = 1'b0;
      @(negedge clk); #1;
      tests++; if (nxmERR !== 1'b0) begin fails++; $display("FAIL tmo_clear: got %b want 0", nxmERR); end
      // memRDY on the terminal-count cycle completes normally
      rd0 = rd_cycles;
      rdy_delay = TMO; rdata = 36'h123456789;
      exp_q.push_back(36'h123456789);
      start(20'h00020, 1'b1, 1'b0, 36'd0);
      wait_ack(200, w);
      exp_din = exp_q.pop_front();
      tests++; if (w !== TMO + 2 || cpuDIN !== exp_din) begin fails++; $display("FAIL tmo_edge: lat %0d din %h want %0d %h", w, cpuDIN, TMO + 2, exp_din); end
      @(negedge clk); #1;
      tests++; if (nxmERR !== 1'b0 || rd_cycles - rd0 !== TMO + 1) begin fails++; $display("FAIL tmo_edge_err: err %b rd %0d want 0 %0d", nxmERR, rd_cycles - rd0, TMO + 1); end
   endtask

   task automatic test_oob();
      int w, rd0;
      rd0 = rd_cycles;
      rdy_delay = 0;
      exp_q.push_back(36'd0);
      nxmCLR = 1'b1;
      start(20'd1024, 1'b1, 1'b0, 36'd0);
      wait_ack(20, w);
      exp_din = exp_q.pop_front();
      tests++; if (w !== 1) begin fails++; $display("FAIL oob_latency: got %0d want 1", w); end
      tests++; if (cpuDIN !== exp_din || rd_cycles - rd0 !== 0) begin fails++; $display("FAIL oob_nxm: din %h rd %0d want 0 0", cpuDIN, rd_cycles - rd0); end
      @(negedge clk); #1;
      tests++; if (nxmERR !== 1'b1) begin fails++; $display("FAIL oob_set_wins: got %b want 1", nxmERR); end
      @(negedge clk); #1;
      tests++; if (nxmERR !== 1'b0) begin fails++; $display("FAIL oob_clear: got %b want 0", nxmERR); end
      nxmCLR = 1'b0;
      rd0 = rd_cycles;
      rdata = 36'o7;
      exp_q.push_back(36'o7);
      start(20'd1023, 1'b1, 1'b0, 36'd0);
      wait_ack(20, w);
      exp_din = exp_q.pop_front();
      tests++; if (w !== 2 || cpuDIN !== exp_din || rd_cycles - rd0 !== 1) begin fails++; $display("FAIL oob_last_word: lat %0d din %h rd %0d want 2 %h 1", w, cpuDIN, rd_cycles - rd0, exp_din); end
      @(negedge clk); #1;
      tests++; if (nxmERR !== 1'b0) begin fails++; $display("FAIL oob_last_err: got %b want 0", nxmERR); end
   endtask

   task automatic test_ignored();
      int rd0, wr0;
      rd0 = rd_cycles; wr0 = wr_cycles;
      @(posedge clk); #1;
      clken = 1'b1; reqSTART = 1'b1; reqREAD = 1'b0; reqWRITE = 1'b0;
      @(posedge clk); #1;
      clken = 1'b0; reqREAD = 1'b1;
      @(posedge clk); #1;
      reqSTART = 1'b0; reqREAD = 1'b0; clken = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      tests++; if (rd_cycles - rd0 !== 0 || wr_cycles - wr0 !== 0 || memWAIT !== 1'b0) begin fails++; $display("FAIL ignored_start: rd %0d wr %0d wait %b want 0 0 0", rd_cycles - rd0, wr_cycles - wr0, memWAIT); end
   endtask

   task automatic test_reset_mid();
      int w, ack0;
      rdy_delay = -1;
      start(20'h00040, 1'b1, 1'b0, 36'd0);
      @(negedge clk); #1;
      tests++; if (mem_if.memRD !== 1'b1) begin fails++; $display("FAIL rstmid_rd: got %b want 1", mem_if.memRD); end
      ack0 = ack_cnt;
      rst = 1'b1;
      #1;
      tests++; if (mem_if.memRD !== 1'b0 || memWAIT !== 1'b0 || memACK !== 1'b0) begin fails++; $display("FAIL rstmid_async: rd %b wait %b ack %b want 0 0 0", mem_if.memRD, memWAIT, memACK); end
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      tests++; if (ack_cnt - ack0 !== 0) begin fails++; $display("FAIL rstmid_noack: got %0d want 0", ack_cnt - ack0); end
      rdy_delay = 0;
      start(20'h00080, 1'b0, 1'b1, 36'o1234);
      wait_ack(20, w);
      tests++; if (w !== 2 || mem_if.memADDR !== 20'h00080 || mem_if.memDOUT !== 36'o1234) begin fails++; $display("FAIL rstmid_restart: lat %0d addr %h dout %o want 2 00080 1234", w, mem_if.memADDR, mem_if.memDOUT); end
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_rmw();
      test_timeout();
      test_oob();
      test_ignored();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
